// File: rtl/uart_byte_tx_core.sv
// 8N1 UART byte transmitter with runtime-selectable baud rate.
// A send_en accepted while idle latches the byte and baud select, then shifts out one frame of 10 bits.
module uart_byte_tx_core #(
   parameter int unsigned CLK_FREQ = 50_000_000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] data_byte_i,
   input  logic       send_en_i,
   input  logic [2:0] baud_set_i,
   output logic       rs232_tx_o,
   output logic       tx_done_o,
   output logic       uart_state_o
);

   localparam int unsigned DIV_9600   = CLK_FREQ / 9600;
   localparam int unsigned DIV_19200  = CLK_FREQ / 19200;
   localparam int unsigned DIV_38400  = CLK_FREQ / 38400;
   localparam int unsigned DIV_57600  = CLK_FREQ / 57600;
   localparam int unsigned DIV_115200 = CLK_FREQ / 115200;
   localparam int unsigned CNT_W      = $clog2(DIV_9600 + 1);
   localparam int unsigned BIT_W      = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   div_q, div_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BIT_W-1:0]   bit_q, bit_d;
   logic [7:0]         data_q, data_d;
   logic               tx_q, tx_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;
   logic               bit_end_c;

   // Baud select to clock divisor; unused codes fall back to 9600.
   function automatic logic [CNT_W-1:0] div_sel(input logic [2:0] sel);
      logic [CNT_W-1:0] div;
      case (sel)
         3'd1:    div = CNT_W'(DIV_19200);
         3'd2:    div = CNT_W'(DIV_38400);
         3'd3:    div = CNT_W'(DIV_57600);
         3'd4:    div = CNT_W'(DIV_115200);
         default: div = CNT_W'(DIV_9600);
      endcase
      return div;
   endfunction

   assign bit_end_c = (cnt_q == (div_q - CNT_W'(1)));

   // bit_q: 0 = start, 1..8 = data bits, 9 = stop
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      data_d  = data_q;
      tx_d    = tx_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (send_en_i) begin
               state_d = S_START;
               data_d  = data_byte_i;
               div_d   = div_sel(baud_set_i);
               cnt_d   = '0;
               bit_d   = '0;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end
         default: begin
            if (bit_end_c) begin
               cnt_d = '0;
               bit_d = bit_q + BIT_W'(1);
               if (state_q == S_STOP) begin
                  state_d = S_IDLE;
                  bit_d   = '0;
                  tx_d    = 1'b1;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else if (bit_q == BIT_W'(8)) begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
               end else begin
                  state_d = S_DATA;
                  tx_d    = data_q[bit_q[2:0]];
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         cnt_q   <= '0;
         bit_q   <= '0;
         data_q  <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         data_q  <= data_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign rs232_tx_o   = tx_q;
   assign tx_done_o    = done_q;
   assign uart_state_o = busy_q;

endmodule

// File: tb/tb_uart_byte_tx_core.sv
// Bench for uart_byte_tx_core: per-cycle frame model plus directed and randomized frames.
module tb_uart_byte_tx_core;

   localparam int unsigned CLK_FREQ = 50_000_000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data_byte = 8'h00;
   logic       send_en = 1'b0;
   logic [2:0] baud_set = 3'd4;
   logic       rs232_tx, tx_done, uart_state;

   int unsigned total = 0;
   int unsigned bad   = 0;

   uart_byte_tx_core #(.CLK_FREQ(CLK_FREQ)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .data_byte_i  (data_byte),
      .send_en_i    (send_en),
      .baud_set_i   (baud_set),
      .rs232_tx_o   (rs232_tx),
      .tx_done_o    (tx_done),
      .uart_state_o (uart_state)
   );

   always #10 clk = ~clk;

   function automatic int unsigned div_of(input logic [2:0] b);
      case (b)
         3'd1:    return CLK_FREQ / 19200;
         3'd2:    return CLK_FREQ / 38400;
         3'd3:    return CLK_FREQ / 57600;
         3'd4:    return CLK_FREQ / 115200;
         default: return CLK_FREQ / 9600;
      endcase
   endfunction

   // Frame model: k counts edges since acceptance, current bit is frame[k/div].
   int unsigned m_k = 0;
   int unsigned m_div = 1;
   logic [9:0]  m_frame = '1;
   logic        m_busy = 1'b0;
   logic        m_line = 1'b1;
   logic        m_done = 1'b0;

   always @(posedge clk) begin
      m_done = 1'b0;
      if (rst) begin
         m_busy = 1'b0;
         m_line = 1'b1;
      end else if (m_busy) begin
         m_k = m_k + 1;
         if (m_k == 10 * m_div) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            m_line = 1'b1;
         end else begin
            m_line = m_frame[m_k / m_div];
         end
      end else if (send_en) begin
         m_busy  = 1'b1;
         m_k     = 0;
         m_frame = {1'b1, data_byte, 1'b0};
         m_div   = div_of(baud_set);
         m_line  = 1'b0;
      end
   end

   always @(negedge clk) begin
      total++;
      if ({rs232_tx, tx_done, uart_state} !== {m_line, m_done, m_busy}) begin
         bad++;
         $display("FAIL model_cmp t=%0t got tx/done/busy=%b%b%b want %b%b%b",
                  $time, rs232_tx, tx_done, uart_state, m_line, m_done, m_busy);
      end
   end

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic wait_done(input string name, input int unsigned budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (tx_done) begin
            seen = 1'b1;
            break;
         end
      end
      chk(name, 32'(seen), 1);
   endtask

   // Send one frame and measure bit pattern, start-bit length, busy length and tx_done timing.
   task automatic run_frame(input string name, input logic [7:0] d, input logic [2:0] b,
                            input int unsigned div_lit, input logic [9:0] bits_lit,
                            input bit mid_pulse);
      logic [9:0]  seq = '0;
      int unsigned busy_cnt = 0, done_cnt = 0, done_at = 0, start_len = 0;
      @(negedge clk);
      send_en = 1'b1; data_byte = d; baud_set = b;
      @(negedge clk);
      send_en = 1'b0; data_byte = 8'($urandom); baud_set = 3'($urandom);
      for (int n = 1; n <= 10 * div_lit + 2; n++) begin
         if (n > 1) @(negedge clk);
         if (uart_state) busy_cnt++;
         if (tx_done) begin done_cnt++; done_at = n; end
         if (n - 1 < 10 * div_lit && (n - 1) % div_lit == div_lit / 2)
            seq[(n - 1) / div_lit] = rs232_tx;
         if (n <= div_lit && !rs232_tx) start_len++;
         if (mid_pulse && n == 5 * div_lit) begin send_en = 1'b1; data_byte = 8'hFF; end
         if (mid_pulse && n == 5 * div_lit + 1) send_en = 1'b0;
      end
      chk({name, "_bits"}, 32'(seq), 32'(bits_lit));
      chk({name, "_start_len"}, start_len, div_lit);
      chk({name, "_busy_len"}, busy_cnt, 10 * div_lit);
      chk({name, "_done_cnt"}, done_cnt, 1);
      chk({name, "_done_at"}, done_at, 10 * div_lit + 1);
   endtask

   initial begin
      #(200_000 * 20);
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  db, dc, dr;
      int unsigned low;

      // Reset held 20 cycles, outputs idle throughout and after release
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("rst_tx", 32'(rs232_tx), 1);
         chk("rst_busy", 32'(uart_state), 0);
         chk("rst_done", 32'(tx_done), 0);
      end
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("post_rst_tx", 32'(rs232_tx), 1);
      chk("post_rst_busy", 32'(uart_state), 0);

      run_frame("aa", 8'hAA, 3'd4, 434, 10'b11_0101_0100, 1'b0);
      repeat (500) @(negedge clk);
      run_frame("55", 8'h55, 3'd4, 434, 10'b10_1010_1010, 1'b0);
      run_frame("busy_pulse", 8'h3C, 3'd4, 434, 10'b10_0111_1000, 1'b1);

      // Back-to-back in the tx_done cycle, then a held send_en re-arming at frame end
      db = 8'($urandom);
      dc = 8'($urandom);
      @(negedge clk);
      send_en = 1'b1; data_byte = 8'h96; baud_set = 3'd4;
      @(negedge clk);
      send_en = 1'b0;
      wait_done("chain_a_done", 5000);
      send_en = 1'b1; data_byte = db;
      @(negedge clk);
      chk("b2b_busy", 32'(uart_state), 1);
      chk("b2b_start", 32'(rs232_tx), 0);
      data_byte = dc;
      wait_done("chain_b_done", 5000);
      chk("held_gap_busy", 32'(uart_state), 0);
      @(negedge clk);
      chk("held_rearm_busy", 32'(uart_state), 1);
      chk("held_rearm_start", 32'(rs232_tx), 0);
      send_en = 1'b0;
      wait_done("chain_c_done", 5000);
      repeat (3) @(negedge clk);

      run_frame("b0", 8'h00, 3'd0, 5208, 10'b10_0000_0000, 1'b0);

      // baud_set 7 maps to 9600: measure start bit, then abort with reset
      @(negedge clk);
      send_en = 1'b1; data_byte = 8'h01; baud_set = 3'd7;
      @(negedge clk);
      send_en = 1'b0;
      low = 0;
      for (int n = 1; n <= 6000; n++) begin
         if (n > 1) @(negedge clk);
         if (rs232_tx) break;
         low++;
      end
      chk("b7_start_len", low, 5208);
      rst = 1'b1;
      @(negedge clk);
      chk("b7_rst_tx", 32'(rs232_tx), 1);
      chk("b7_rst_busy", 32'(uart_state), 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Reset inside data bit 3 at 115200
      @(negedge clk);
      send_en = 1'b1; data_byte = 8'h00; baud_set = 3'd4;
      @(negedge clk);
      send_en = 1'b0;
      repeat (4 * 434 + 199) @(negedge clk);
      chk("t6_in_bit3_busy", 32'(uart_state), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_tx", 32'(rs232_tx), 1);
      chk("t6_rst_busy", 32'(uart_state), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("t6_no_done", 32'(tx_done), 0);
      end

      dr = 8'($urandom);
      run_frame("post_abort", dr, 3'd4, 434, {1'b1, dr, 1'b0}, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
